// File: rtl/miner_job_loader.sv
// Loads 52-byte mining jobs from a SYNC_BYTE-framed byte stream and buffers one miner result.
// Build option: define JOB_CHECKSUM_EN to require a trailing XOR checksum byte (CHECK state).
module miner_job_loader #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         RX_TIMEOUT = 1024
) (
  input  logic         hash_clk,
  input  logic         reset_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [255:0] midstate,
  output logic [95:0]  work_data,
  output logic [31:0]  nonce_min,
  output logic [31:0]  nonce_max,
  output logic         miner_reset,
  input  logic [31:0]  golden_nonce,
  input  logic         new_golden_nonce,
  output logic [31:0]  result_nonce,
  output logic [7:0]   result_job,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [7:0]   job_id,
  output logic         overflow
);

  localparam int               PAYLOAD_BYTES = 52;
  localparam int               SHADOW_W      = PAYLOAD_BYTES * 8;
  localparam int               TMO_W         = $clog2(RX_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST      = TMO_W'(RX_TIMEOUT - 1);
  localparam logic [5:0]       LAST_BYTE     = 6'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
`ifdef JOB_CHECKSUM_EN
    CHECK  = 2'd2,
`endif
    LAUNCH = 2'd3
  } state_t;

  // Field order matches the wire order, so shifting bytes in MSB-first fills it directly.
  typedef struct packed {
    logic [255:0] midstate;
    logic [95:0]  work_data;
    logic [31:0]  nonce_min;
    logic [31:0]  nonce_max;
  } job_t;

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  job_t             shadow_q, shadow_d;
  job_t             job_q, job_d;
  logic             miner_reset_q, miner_reset_d;
  logic [7:0]       job_id_q, job_id_d;
  logic [31:0]      result_nonce_q, result_nonce_d;
  logic [7:0]       result_job_q, result_job_d;
  logic             result_valid_q, result_valid_d;
  logic             overflow_q, overflow_d;
  logic             ngn_q;
`ifdef JOB_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic rx_xfer;
  logic ngn_rise;

  assign rx_ready = (state_q != LAUNCH);
  assign rx_xfer  = rx_valid && rx_ready;
  assign ngn_rise = new_golden_nonce && !ngn_q;

  // Frame receiver and job launch.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    shadow_d      = shadow_q;
    job_d         = job_q;
    job_id_d      = job_id_q;
    miner_reset_d = 1'b0;
`ifdef JOB_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (rx_xfer && rx_data == SYNC_BYTE) begin
          state_d = LOAD;
          cnt_d   = '0;
`ifdef JOB_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LOAD: begin
        if (rx_xfer) begin
          shadow_d = {shadow_q[SHADOW_W-9:0], rx_data};
          cnt_d    = cnt_q + 6'd1;
          tmo_d    = '0;
`ifdef JOB_CHECKSUM_EN
          csum_d   = csum_q ^ rx_data;
          if (cnt_q == LAST_BYTE) state_d = CHECK;
`else
          if (cnt_q == LAST_BYTE) begin
            state_d       = LAUNCH;
            job_d         = shadow_d;
            miner_reset_d = 1'b1;
          end
`endif
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`ifdef JOB_CHECKSUM_EN
      CHECK: begin
        if (rx_xfer) begin
          tmo_d = '0;
          if (rx_data == csum_q) begin
            state_d       = LAUNCH;
            job_d         = shadow_q;
            miner_reset_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`endif
      LAUNCH: begin
        // job_id steps on leaving LAUNCH so results arriving in this cycle carry the old id.
        job_id_d = job_id_q + 8'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One-deep result buffer with sticky loss flag.
  always_comb begin
    result_nonce_d = result_nonce_q;
    result_job_d   = result_job_q;
    result_valid_d = result_valid_q;
    overflow_d     = overflow_q;
    if (ngn_rise) begin
      if (!result_valid_q || result_ready) begin
        result_nonce_d = golden_nonce;
        result_job_d   = job_id_q;
        result_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (result_valid_q && result_ready) begin
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tmo_q          <= '0;
      job_q          <= '0;
      miner_reset_q  <= 1'b0;
      job_id_q       <= '0;
      result_nonce_q <= '0;
      result_job_q   <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      ngn_q          <= 1'b0;
`ifdef JOB_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its inputs.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tmo_q          <= tmo_d;
      job_q          <= job_d;
      miner_reset_q  <= miner_reset_d;
      job_id_q       <= job_id_d;
      result_nonce_q <= result_nonce_d;
      result_job_q   <= result_job_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      ngn_q          <= new_golden_nonce;
`ifdef JOB_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

  // NOTE: the shadow is pure datapath and is left unreset; every byte is rewritten before a launch reads it.
  always_ff @(posedge hash_clk) begin
    shadow_q <= shadow_d;
  end

  assign midstate     = job_q.midstate;
  assign work_data    = job_q.work_data;
  assign nonce_min    = job_q.nonce_min;
  assign nonce_max    = job_q.nonce_max;
  assign miner_reset  = miner_reset_q;
  assign job_id       = job_id_q;
  assign result_nonce = result_nonce_q;
  assign result_job   = result_job_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_miner_job_loader.sv
// Randomized frame/result bench for miner_job_loader with a byte-array reference model.
// Honours JOB_CHECKSUM_EN the same way as the design (adds the checksum byte and its test).
module tb_miner_job_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 1024;

  logic         hash_clk = 1'b0;
  logic         reset_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [255:0] midstate;
  logic [95:0]  work_data;
  logic [31:0]  nonce_min, nonce_max;
  logic         miner_reset;
  logic [31:0]  golden_nonce;
  logic         new_golden_nonce;
  logic [31:0]  result_nonce;
  logic [7:0]   result_job;
  logic         result_valid;
  logic         result_ready;
  logic [7:0]   job_id;
  logic         overflow;

  miner_job_loader #(.SYNC_BYTE(SYNC), .RX_TIMEOUT(TMO)) dut (
    .hash_clk(hash_clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .midstate(midstate), .work_data(work_data), .nonce_min(nonce_min), .nonce_max(nonce_max),
    .miner_reset(miner_reset),
    .golden_nonce(golden_nonce), .new_golden_nonce(new_golden_nonce),
    .result_nonce(result_nonce), .result_job(result_job),
    .result_valid(result_valid), .result_ready(result_ready),
    .job_id(job_id), .overflow(overflow)
  );

  always #5 hash_clk = ~hash_clk;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  // Reference model: what the miner should currently be holding.
  logic [255:0] exp_ms;
  logic [95:0]  exp_wd;
  logic [31:0]  exp_n0, exp_n1;
  logic [7:0]   exp_job;
  logic [7:0]   pay [52];

  always @(posedge hash_clk) if (miner_reset === 1'b1) pulse_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    exp_ms = '0; exp_wd = '0; exp_n0 = '0; exp_n1 = '0; exp_job = '0;
  endtask

  task automatic fill_pay(input bit with_sync);
    for (int i = 0; i < 52; i++) pay[i] = 8'($urandom);
    if (with_sync) pay[$urandom_range(0, 51)] = SYNC;
  endtask

  task automatic push_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge hash_clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 8 && rx_ready !== 1'b1; t++) begin @(posedge hash_clk); #1; end
    if (rx_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL rx_ready_wait: rx_ready=%b, required 1 within 8 cycles", rx_ready);
    end
    @(posedge hash_clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_held(input string tag);
    n_vec++;
    if ({midstate, work_data, nonce_min, nonce_max, job_id, miner_reset} !== {exp_ms, exp_wd, exp_n0, exp_n1, exp_job, 1'b0}) begin
      n_err++;
      $display("FAIL %s held_outputs: got ms=%h id=%h mr=%b, required ms=%h id=%h mr=0", tag, midstate, job_id, miner_reset, exp_ms, exp_job);
    end
  endtask

  // Sends sync + payload (+ checksum); returns #1 after the last accepted byte.
  task automatic send_frame(input int max_gap, input bit cs_good, input int stall_at, input int stall_len);
    logic [7:0] cs;
    int gap;
    cs = '0;
    for (int i = 0; i < 52; i++) cs = cs ^ pay[i];
    push_byte(SYNC, $urandom_range(0, max_gap));
    for (int i = 0; i < 52; i++) begin
      gap = (i == stall_at) ? stall_len : int'($urandom_range(0, max_gap));
      if (i == 30) check_held("mid_frame");
      push_byte(pay[i], gap);
    end
`ifdef JOB_CHECKSUM_EN
    push_byte(cs_good ? cs : (cs ^ 8'h5A), $urandom_range(0, max_gap));
`else
    if (cs_good) cs = '0;
`endif
  endtask

  // Called in the cycle right after the last frame byte.
  task automatic check_launch(input string tag);
    logic [255:0] ms;
    logic [95:0]  wd;
    logic [31:0]  n0, n1;
    for (int i = 0; i < 32; i++) ms[255-8*i -: 8] = pay[i];
    for (int i = 0; i < 12; i++) wd[95-8*i -: 8] = pay[32+i];
    for (int i = 0; i < 4; i++) begin
      n0[31-8*i -: 8] = pay[44+i];
      n1[31-8*i -: 8] = pay[48+i];
    end
    n_vec++;
    if (miner_reset !== 1'b1) begin n_err++; $display("FAIL %s miner_reset_n1: got %b, required 1", tag, miner_reset); end
    n_vec++;
    if ({midstate, work_data, nonce_min, nonce_max} !== {ms, wd, n0, n1}) begin
      n_err++;
      $display("FAIL %s job_outputs: got %h, required %h", tag, {midstate, work_data, nonce_min, nonce_max}, {ms, wd, n0, n1});
    end
    n_vec++;
    if (job_id !== exp_job) begin n_err++; $display("FAIL %s job_id_in_launch: got %h, required %h", tag, job_id, exp_job); end
    n_vec++;
    if (rx_ready !== 1'b0) begin n_err++; $display("FAIL %s rx_ready_in_launch: got %b, required 0", tag, rx_ready); end
    exp_ms = ms; exp_wd = wd; exp_n0 = n0; exp_n1 = n1;
    exp_job = exp_job + 8'd1;
    @(posedge hash_clk); #1;
    check_held(tag);
  endtask

  task automatic pulse_ngn(input logic [31:0] g);
    new_golden_nonce = 1'b0;
    @(posedge hash_clk); #1;
    new_golden_nonce = 1'b1;
    golden_nonce     = g;
    @(posedge hash_clk); #1;
    new_golden_nonce = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    n_vec++;
    if ({midstate, work_data, nonce_min, nonce_max, job_id, miner_reset, result_nonce, result_job, result_valid, overflow} !== '0 || rx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s reset_state: got ms=%h id=%h mr=%b rn=%h rj=%h rv=%b ov=%b rdy=%b, required all 0 and rdy=1",
               tag, midstate, job_id, miner_reset, result_nonce, result_job, result_valid, overflow, rx_ready);
    end
  endtask

  task automatic test_reset();
    int pc;
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = '0;
    golden_nonce = '0; new_golden_nonce = 1'b0; result_ready = 1'b0;
    model_reset();
    #3;
    check_all_zero("reset");
    repeat (2) begin @(posedge hash_clk); #1; end
    pc = pulse_cnt;
    reset_n = 1'b1;
    repeat (3) begin @(posedge hash_clk); #1; end
    n_vec++;
    if (pulse_cnt !== pc) begin n_err++; $display("FAIL reset_release_pulse: got %0d pulses, required %0d", pulse_cnt, pc); end
    check_all_zero("after_release");
  endtask

  task automatic test_directed_frame();
    int pc;
    for (int i = 0; i < 44; i++) pay[i] = 8'(i);
    for (int i = 44; i < 48; i++) pay[i] = 8'h00;
    for (int i = 48; i < 52; i++) pay[i] = 8'hFF;
    pc = pulse_cnt;
    send_frame(0, 1'b1, -1, 0);
    check_launch("directed");
    n_vec++;
    if (midstate !== 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f || work_data !== 96'h202122232425262728292a2b) begin
      n_err++; $display("FAIL directed_literal: got ms=%h wd=%h", midstate, work_data);
    end
    n_vec++;
    if (job_id !== 8'd1 || pulse_cnt !== pc + 1) begin
      n_err++; $display("FAIL directed_count: got id=%h pulses=%0d, required id=01 pulses=%0d", job_id, pulse_cnt - pc, 1);
    end
  endtask

  task automatic test_garbage_prefix();
    fill_pay(1'b0);
    push_byte(8'h00, 0);
    push_byte(8'h3C, 1);
    send_frame(1, 1'b1, -1, 0);
    check_launch("garbage_prefix");
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 6; k++) begin
      fill_pay(1'b1);
      send_frame(3, 1'b1, -1, 0);
      check_launch("random_frame");
    end
  endtask

  task automatic test_timeout();
    int pc;
    fill_pay(1'b0);
    pc = pulse_cnt;
    push_byte(SYNC, 0);
    for (int i = 0; i < 10; i++) push_byte(pay[i], 0);
    repeat (TMO) begin @(posedge hash_clk); #1; end
    check_held("timeout_abort");
    n_vec++;
    if (pulse_cnt !== pc) begin n_err++; $display("FAIL timeout_pulse: got %0d pulses, required 0", pulse_cnt - pc); end
    fill_pay(1'b1);
    send_frame(2, 1'b1, -1, 0);
    check_launch("after_timeout");
    fill_pay(1'b0);
    send_frame(0, 1'b1, 10, TMO - 1);
    check_launch("stall_below_timeout");
  endtask

  task automatic test_results();
    logic [31:0] g2, g3, g4, g5;
    logic [7:0]  pre;
    g2 = $urandom; g3 = $urandom; g4 = $urandom; g5 = $urandom;
    result_ready = 1'b0;
    pulse_ngn(32'h1234ABCD);
    n_vec++;
    if ({result_valid, result_nonce, result_job, overflow} !== {1'b1, 32'h1234ABCD, exp_job, 1'b0}) begin
      n_err++; $display("FAIL first_result: got v=%b n=%h j=%h ov=%b, required v=1 n=1234abcd j=%h ov=0", result_valid, result_nonce, result_job, overflow, exp_job);
    end
    pulse_ngn(g2);
    n_vec++;
    if ({result_valid, result_nonce, overflow} !== {1'b1, 32'h1234ABCD, 1'b1}) begin
      n_err++; $display("FAIL dropped_result: got v=%b n=%h ov=%b, required v=1 n=1234abcd ov=1", result_valid, result_nonce, overflow);
    end
    result_ready = 1'b1;
    @(posedge hash_clk); #1;
    n_vec++;
    if ({result_valid, overflow} !== 2'b01) begin n_err++; $display("FAIL result_drain: got v=%b ov=%b, required v=0 ov=1", result_valid, overflow); end
    result_ready = 1'b0;
    pulse_ngn(g3);
    @(posedge hash_clk); #1;
    result_ready = 1'b1; new_golden_nonce = 1'b1; golden_nonce = g4;
    @(posedge hash_clk); #1;
    new_golden_nonce = 1'b0;
    n_vec++;
    if ({result_valid, result_nonce} !== {1'b1, g4}) begin
      n_err++; $display("FAIL coincide_capture: got v=%b n=%h, required v=1 n=%h", result_valid, result_nonce, g4);
    end
    @(posedge hash_clk); #1;
    n_vec++;
    if ({result_valid, overflow} !== 2'b01) begin n_err++; $display("FAIL coincide_drain: got v=%b ov=%b, required v=0 ov=1", result_valid, overflow); end
    fill_pay(1'b0);
    send_frame(1, 1'b1, -1, 0);
    pre = exp_job;
    new_golden_nonce = 1'b1; golden_nonce = g5;
    check_launch("launch_tag_frame");
    new_golden_nonce = 1'b0;
    result_ready = 1'b0;
    n_vec++;
    if ({result_valid, result_nonce, result_job} !== {1'b1, g5, pre}) begin
      n_err++; $display("FAIL launch_tag: got v=%b n=%h j=%h, required v=1 n=%h j=%h", result_valid, result_nonce, result_job, g5, pre);
    end
  endtask

`ifdef JOB_CHECKSUM_EN
  task automatic test_checksum();
    int pc;
    fill_pay(1'b0);
    pc = pulse_cnt;
    send_frame(1, 1'b0, -1, 0);
    repeat (2) begin @(posedge hash_clk); #1; end
    check_held("bad_checksum");
    n_vec++;
    if (pulse_cnt !== pc) begin n_err++; $display("FAIL bad_checksum_pulse: got %0d pulses, required 0", pulse_cnt - pc); end
    fill_pay(1'b1);
    send_frame(1, 1'b1, -1, 0);
    check_launch("good_checksum");
  endtask
`endif

  task automatic test_reset_mid_load();
    int pc;
    result_ready = 1'b0;
    pulse_ngn($urandom);
    fill_pay(1'b0);
    push_byte(SYNC, 0);
    for (int i = 0; i < 5; i++) push_byte(pay[i], 0);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("reset_mid_load");
    repeat (2) begin @(posedge hash_clk); #1; end
    pc = pulse_cnt;
    reset_n = 1'b1;
    repeat (3) begin @(posedge hash_clk); #1; end
    check_held("after_mid_reset");
    n_vec++;
    if (pulse_cnt !== pc) begin n_err++; $display("FAIL mid_reset_pulse: got %0d pulses, required 0", pulse_cnt - pc); end
    fill_pay(1'b1);
    send_frame(2, 1'b1, -1, 0);
    check_launch("post_reset_frame");
    n_vec++;
    if (job_id !== 8'd1) begin n_err++; $display("FAIL post_reset_job_id: got %h, required 01", job_id); end
  endtask

  initial begin
    test_reset();
    test_directed_frame();
    test_garbage_prefix();
    test_random_frames();
    test_timeout();
    test_results();
`ifdef JOB_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/miner_job_loader.md
MINER_JOB_LOADER -- requirements
Module: miner_job_loader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter RX_TIMEOUT, default 1024, max idle cycles between bytes inside a frame.
REQ-003 SHALL have port hash_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  8  job byte stream.
REQ-006 SHALL have port rx_valid  input  1  rx_data valid.
REQ-007 SHALL have port rx_ready  output  1  loader accepts byte; a transfer occurs when rx_valid and rx_ready are both high.
REQ-008 SHALL have ports midstate (output, 256), work_data (output, 96), nonce_min (output, 32) and nonce_max (output, 32); all are registered job outputs to the miner.
REQ-009 SHALL have port miner_reset  output  1  active-high one-cycle job start pulse to the miner.
REQ-010 SHALL have ports golden_nonce (input, 32) and new_golden_nonce (input, 1); these carry the miner result.
REQ-011 SHALL have ports result_nonce (output, 32) and result_job (output, 8); these form the result payload.
REQ-012 SHALL have ports result_valid (output, 1) and result_ready (input, 1); these form the result handshake.
REQ-013 SHALL have port job_id  output  8  count of launched jobs.
REQ-014 SHALL have port overflow  output  1  sticky flag: a result was lost.

Function
REQ-015 SHALL implement the states IDLE, LOAD, CHECK and LAUNCH.
REQ-016 In IDLE, the block SHALL discard every accepted byte except SYNC_BYTE; SYNC_BYTE SHALL move the state to LOAD with the byte count cleared.
REQ-017 In LOAD, the block SHALL accept 52 payload bytes into a shadow register, MSB-first, in this order: midstate[255:0], work_data[95:0], nonce_min, nonce_max.
REQ-018 After the 52nd byte, the block SHALL go to CHECK when JOB_CHECKSUM_EN is defined and to LAUNCH otherwise.
REQ-019 In LAUNCH (one cycle), the block SHALL copy the shadow register to the job outputs, drive miner_reset high, increment job_id (mod 256) and return to IDLE.
REQ-020 Launch latency SHALL be one cycle: the final frame byte accepted at cycle N gives miner_reset=1 and new outputs at N+1.
REQ-021 rx_ready SHALL be 1 in IDLE, LOAD and CHECK, and 0 in LAUNCH.
REQ-022 The job outputs SHALL change only in LAUNCH and SHALL remain stable while a new frame is being received.
REQ-023 In LOAD or CHECK, RX_TIMEOUT consecutive cycles without a transfer SHALL abort the frame to IDLE; the job outputs and job_id SHALL stay unchanged and no miner_reset SHALL be issued.
REQ-024 SYNC_BYTE received inside LOAD SHALL be treated as payload data, not as a restart.
REQ-025 The block SHALL capture the result on the rising edge of new_golden_nonce: result_nonce=golden_nonce, result_job=the job_id current in that cycle, and result_valid=1.
REQ-026 result_valid SHALL clear on the cycle after a result_valid&&result_ready transfer.
REQ-027 A rising edge of new_golden_nonce while result_valid=1 and result_ready=0 SHALL be dropped and SHALL set overflow.
REQ-028 A rising edge of new_golden_nonce coinciding with a completing transfer SHALL be captured, with result_valid remaining 1.
REQ-029 A rising edge of new_golden_nonce in the LAUNCH cycle SHALL be tagged with the pre-increment job_id.
REQ-030 overflow SHALL clear only on reset.

Reset
REQ-031 When reset_n=0, the block SHALL asynchronously set: state IDLE, byte count 0, timeout counter 0, rx_ready 1, miner_reset 0, job outputs 0, job_id 0, result_nonce 0, result_job 0, result_valid 0, overflow 0, and the new_golden_nonce edge register 0.
REQ-032 A reset during LOAD SHALL discard the partial frame.
REQ-033 Release of reset SHALL not generate a miner_reset pulse.

Configuration
REQ-034 With macro JOB_CHECKSUM_EN defined, CHECK SHALL accept one byte; if that byte equals the XOR of the 52 payload bytes the block SHALL go to LAUNCH, otherwise it SHALL go to IDLE with no launch.
REQ-035 Without JOB_CHECKSUM_EN, the CHECK state SHALL be absent and the frame SHALL be 53 bytes (sync byte plus payload).

Verification
REQ-036 Frame A5, midstate bytes 00..1F, work_data 20..2B, nonce_min 00000000, nonce_max FFFFFFFF -> midstate=256'h000102..1F, miner_reset high exactly one cycle after the last byte, job_id=1.
REQ-037 Bytes 00, 3C, A5 followed by a valid payload -> the leading bytes are ignored and the job launches.
REQ-038 A frame stalled after 10 payload bytes for 1024 cycles -> return to IDLE; outputs, job_id and miner_reset unchanged; the next full frame launches normally.
REQ-039 new_golden_nonce pulse with golden_nonce=32'h1234ABCD and result_ready=0 -> result_valid=1, result_nonce=1234ABCD, result_job=job_id; a second pulse -> overflow=1 and result_nonce still 1234ABCD.
REQ-040 With JOB_CHECKSUM_EN, a wrong checksum byte -> no launch and job_id unchanged; a correct checksum byte -> launch.
REQ-041 reset_n asserted mid-LOAD with result_valid=1 -> all outputs return to 0 immediately, and a full frame received afterwards launches with job_id=1.
